hsid_mse_comp: RTL and testbench
================================

// Module: hsid_mse_comp
// PURPOSE
// Downstream stage of the MSE unit: consumes the stream of (mse_value, mse_ref) results, one per library vector.
// Tracks the library vector with minimum MSE (best match) and the one with maximum MSE over one search of library_size vectors.
// Reports the final classification with a one-cycle done pulse.
// PARAMETERS
// WORD_WIDTH         HSID_WORD_WIDTH         width of mse_value and min/max value outputs
// HSP_LIBRARY_WIDTH  HSID_HSP_LIBRARY_WIDTH  width of vector refs and of library_size/counter
// PORTS
// clk           in   1                  clock
// rst_n         in   1                  reset, asynchronous, active-low
// clear         in   1                  synchronous clear, highest priority after rst_n
// start         in   1                  begin a search; samples library_size
// library_size  in   HSP_LIBRARY_WIDTH  number of MSE results expected in this search
// mse_value     in   WORD_WIDTH         MSE result from MSE unit
// mse_ref       in   HSP_LIBRARY_WIDTH  library ref of mse_value
// mse_valid     in   1                  mse_value/mse_ref/mse_of/acc_of valid this cycle
// mse_of        in   1                  MSE division/result overflow
// acc_of        in   1                  accumulator overflow for this vector
// busy          out  1                  search in progress (state RUN)
// done          out  1                  one-cycle pulse: search complete, results valid
// min_value     out  WORD_WIDTH         smallest MSE seen
// min_ref       out  HSP_LIBRARY_WIDTH  ref of smallest MSE
// max_value     out  WORD_WIDTH         largest MSE seen
// max_ref       out  HSP_LIBRARY_WIDTH  ref of largest MSE
// of_seen       out  1                  sticky: any sample in search had mse_of|acc_of
// error         out  1                  sticky protocol error (see below)
// BEHAVIOUR
// - Reset (rst_n=0) and clear: all outputs 0, state IDLE, count 0; clear applies on next edge, overrides every event.
// - FSM IDLE -> RUN on start with library_size!=0; library_size latched into size_q, count=0, of_seen=0, error kept.
// - start with library_size==0: stay IDLE, set error.
// - RUN: each mse_valid compares and count++; on mse_valid with count==size_q-1 -> DONE.
// - DONE: lasts exactly one cycle, done=1; then IDLE. done rises the cycle after the last mse_valid.
// - Overflowed sample (mse_of|acc_of): effective value = all-ones ('1) for both comparisons; of_seen set.
// - First sample of a search (count==0) loads min and max unconditionally.
// - Later samples: min updates only on eff < min_value, max only on eff > max_value; ties keep the earlier ref.
// - Refs are taken from mse_ref, never from count; out-of-order refs are legal.
// - min/max outputs are registered, update during RUN, and hold after DONE until next start or clear.
// - mse_valid in IDLE or DONE: sample ignored, error set; mse_valid coincident with start in IDLE: ignored, error set.
// - start while RUN or DONE: ignored, no error.
// - Unsigned compare, no arithmetic widening; count wraps are impossible since count < size_q.
// STRUCTURE
// - hsid_pkg gains: typedef enum logic [1:0] {MSE_COMP_IDLE, MSE_COMP_RUN, MSE_COMP_DONE} hsid_mse_comp_state_t.
// - Sub-module hsid_mse_extreme #(WORD_WIDTH, HSP_LIBRARY_WIDTH, IS_MAX): value/ref register with load/compare-update.
//   Instantiated twice (IS_MAX=0, 1).
// - Top holds FSM, count, size_q, of_seen/error flags, overflow saturation mux.
// - SVA bind module: done one cycle after last valid; busy==(state==RUN); outputs zero cycle after clear.
// TESTING
// - start, size=4; values 40@r0, 12@r1, 90@r2, 12@r3 -> done 1 cycle after r3, min=12/r1, max=90/r2, of_seen=0.
// - size=3; 7@r5, 7@r6 (mse_of=1), 3@r7 -> min=3/r7, max='1/r6, of_seen=1.
// - size=1; 'hFFFF_FFFF@r9 -> min=max='1, ref 9 from first-sample load, done pulse 1 cycle.
// - mse_valid in IDLE, then start with library_size=0 -> error=1, busy=0, no done.
// - clear mid-RUN after 2 of 5 samples -> next cycle all outputs 0, IDLE; fresh size=2 search completes correctly.
// - rst_n low asynchronously during RUN -> outputs 0 immediately; start asserted while RUN ignored (count unchanged).

Source files
------------

// File: rtl/hsid_mse_comp_pkg.sv
// -----------------------------------------------------------------------------
// hsid_mse_comp_pkg
// Shared widths and state encoding for the MSE comparator stage.
// Contents:
//   HSID_WORD_WIDTH          default width of MSE values
//   HSID_HSP_LIBRARY_WIDTH   default width of library refs / sizes / counters
//   hsid_mse_comp_state_t    comparator FSM states
// -----------------------------------------------------------------------------
package hsid_mse_comp_pkg;

  localparam int HSID_WORD_WIDTH        = 32;
  localparam int HSID_HSP_LIBRARY_WIDTH = 8;

  typedef enum logic [1:0] {
    MSE_COMP_IDLE = 2'd0,
    MSE_COMP_RUN  = 2'd1,
    MSE_COMP_DONE = 2'd2
  } hsid_mse_comp_state_t;

endpackage

// File: rtl/hsid_mse_comp_if.sv
// -----------------------------------------------------------------------------
// hsid_mse_comp_if
// Control, result-stream and classification signals of the MSE comparator.
// Modports:
//   slave  - the comparator: consumes clear/start/library_size/mse_* and
//            produces busy/done/min_*/max_*/of_seen/error
//   master - the environment driving the comparator
// -----------------------------------------------------------------------------
interface hsid_mse_comp_if
  import hsid_mse_comp_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) ();

  logic                         clear;
  logic                         start;
  logic [HSP_LIBRARY_WIDTH-1:0] library_size;
  logic [WORD_WIDTH-1:0]        mse_value;
  logic [HSP_LIBRARY_WIDTH-1:0] mse_ref;
  logic                         mse_valid;
  logic                         mse_of;
  logic                         acc_of;
  logic                         busy;
  logic                         done;
  logic [WORD_WIDTH-1:0]        min_value;
  logic [HSP_LIBRARY_WIDTH-1:0] min_ref;
  logic [WORD_WIDTH-1:0]        max_value;
  logic [HSP_LIBRARY_WIDTH-1:0] max_ref;
  logic                         of_seen;
  logic                         error;

  modport slave (
    input  clear, start, library_size, mse_value, mse_ref, mse_valid, mse_of, acc_of,
    output busy, done, min_value, min_ref, max_value, max_ref, of_seen, error
  );

  modport master (
    output clear, start, library_size, mse_value, mse_ref, mse_valid, mse_of, acc_of,
    input  busy, done, min_value, min_ref, max_value, max_ref, of_seen, error
  );

endinterface

// File: rtl/hsid_mse_comp_sva.sv
// -----------------------------------------------------------------------------
// hsid_mse_comp_sva
// Property checker bound into hsid_mse_comp.
// Ports: clock/reset, clear, FSM state, last-sample strobe, and all status and
// result registers of the comparator.
// -----------------------------------------------------------------------------
module hsid_mse_comp_sva
  import hsid_mse_comp_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
  input logic                         clk,
  input logic                         rst_n,
  input logic                         clear,
  input hsid_mse_comp_state_t         state,
  input logic                         last_valid,
  input logic                         busy,
  input logic                         done,
  input logic                         of_seen,
  input logic                         error,
  input logic [WORD_WIDTH-1:0]        min_value,
  input logic [HSP_LIBRARY_WIDTH-1:0] min_ref,
  input logic [WORD_WIDTH-1:0]        max_value,
  input logic [HSP_LIBRARY_WIDTH-1:0] max_ref
);

  a_done_after_last: assert property (@(posedge clk) disable iff (!rst_n)
    (last_valid && !clear) |=> done);

  a_busy_is_run: assert property (@(posedge clk) disable iff (!rst_n)
    busy == (state == MSE_COMP_RUN));

  a_clear_zeroes: assert property (@(posedge clk) disable iff (!rst_n)
    clear |=> (!busy && !done && !of_seen && !error &&
               (min_value == {WORD_WIDTH{1'b0}}) && (max_value == {WORD_WIDTH{1'b0}}) &&
               (min_ref == {HSP_LIBRARY_WIDTH{1'b0}}) && (max_ref == {HSP_LIBRARY_WIDTH{1'b0}}) &&
               (state == MSE_COMP_IDLE)));

endmodule

bind hsid_mse_comp hsid_mse_comp_sva #(
  .WORD_WIDTH        (WORD_WIDTH),
  .HSP_LIBRARY_WIDTH (HSP_LIBRARY_WIDTH)
) u_sva (
  .clk        (clk),
  .rst_n      (rst_n),
  .clear      (clear_s),
  .state      (state_r),
  .last_valid (last_valid_s),
  .busy       (busy_r),
  .done       (done_r),
  .of_seen    (of_seen_r),
  .error      (error_r),
  .min_value  (min_value_s),
  .min_ref    (min_ref_s),
  .max_value  (max_value_s),
  .max_ref    (max_ref_s)
);

// File: rtl/hsid_mse_extreme.sv
// -----------------------------------------------------------------------------
// hsid_mse_extreme
// Holds one extreme (minimum when IS_MAX=0, maximum when IS_MAX=1) of a
// stream of samples together with the ref that produced it.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear          synchronous clear of value and ref
//   sample_valid   a sample is presented this cycle
//   first_sample   load the sample unconditionally (first of a search)
//   sample_value   effective sample value (already saturated on overflow)
//   sample_ref     library ref of the sample
//   ext_value      registered extreme value
//   ext_ref        registered ref of the extreme value
// -----------------------------------------------------------------------------
module hsid_mse_extreme
  import hsid_mse_comp_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
  parameter bit IS_MAX            = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         sample_valid,
  input  logic                         first_sample,
  input  logic [WORD_WIDTH-1:0]        sample_value,
  input  logic [HSP_LIBRARY_WIDTH-1:0] sample_ref,
  output logic [WORD_WIDTH-1:0]        ext_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] ext_ref
);

  logic [WORD_WIDTH-1:0]        value_r;
  logic [HSP_LIBRARY_WIDTH-1:0] ref_r;
  logic                         better_s;
  logic                         take_s;

  // Strict comparison so that ties keep the earlier ref.
  always_comb begin
    better_s = 1'b0;
    if (IS_MAX) begin
      better_s = (sample_value > value_r);
    end else begin
      better_s = (sample_value < value_r);
    end
    take_s = sample_valid & (first_sample | better_s);
  end

  // Extreme value/ref register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= {WORD_WIDTH{1'b0}};
      ref_r   <= {HSP_LIBRARY_WIDTH{1'b0}};
    end else if (clear) begin
      value_r <= {WORD_WIDTH{1'b0}};
      ref_r   <= {HSP_LIBRARY_WIDTH{1'b0}};
    end else if (take_s) begin
      value_r <= sample_value;
      ref_r   <= sample_ref;
    end else begin
      value_r <= value_r;
      ref_r   <= ref_r;
    end
  end

  assign ext_value = value_r;
  assign ext_ref   = ref_r;

endmodule

// File: rtl/hsid_mse_comp.sv
// -----------------------------------------------------------------------------
// hsid_mse_comp
// Downstream stage of the MSE unit. Over one search of library_size results it
// tracks the best match (minimum MSE) and the worst match (maximum MSE) and
// signals completion with a one-cycle done pulse.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          hsid_mse_comp_if.slave:
//                  clear/start/library_size      search control
//                  mse_value/mse_ref/mse_valid   result stream
//                  mse_of/acc_of                 per-sample overflow flags
//                  busy/done                     search status
//                  min_*/max_*                   registered extremes
//                  of_seen/error                 sticky flags
// -----------------------------------------------------------------------------
module hsid_mse_comp
  import hsid_mse_comp_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  hsid_mse_comp_if.slave bus
);

  hsid_mse_comp_state_t         state_r;
  hsid_mse_comp_state_t         state_next;
  logic [HSP_LIBRARY_WIDTH-1:0] count_r;
  logic [HSP_LIBRARY_WIDTH-1:0] size_r;
  logic                         busy_r;
  logic                         done_r;
  logic                         of_seen_r;
  logic                         error_r;

  logic                         clear_s;
  logic                         start_s;
  logic [HSP_LIBRARY_WIDTH-1:0] library_size_s;
  logic                         mse_valid_s;
  logic                         ovf_s;
  logic [WORD_WIDTH-1:0]        eff_value_s;
  logic                         run_sample_s;
  logic                         last_sample_s;
  logic                         last_valid_s;
  logic                         start_accept_s;
  logic                         proto_err_s;
  logic                         ext_clear_s;
  logic                         first_sample_s;
  logic [WORD_WIDTH-1:0]        min_value_s;
  logic [HSP_LIBRARY_WIDTH-1:0] min_ref_s;
  logic [WORD_WIDTH-1:0]        max_value_s;
  logic [HSP_LIBRARY_WIDTH-1:0] max_ref_s;

  assign clear_s        = bus.clear;
  assign start_s        = bus.start;
  assign library_size_s = bus.library_size;
  assign mse_valid_s    = bus.mse_valid;

  // Overflowed samples saturate to all-ones so they never win the minimum
  // and always dominate the maximum.
  assign ovf_s       = bus.mse_of | bus.acc_of;
  assign eff_value_s = ovf_s ? {WORD_WIDTH{1'b1}} : bus.mse_value;

  assign run_sample_s   = (state_r == MSE_COMP_RUN) & mse_valid_s;
  assign last_sample_s  = (count_r == (size_r - HSP_LIBRARY_WIDTH'(1)));
  assign last_valid_s   = run_sample_s & last_sample_s;
  assign start_accept_s = (state_r == MSE_COMP_IDLE) & start_s &
                          (library_size_s != {HSP_LIBRARY_WIDTH{1'b0}});
  // Samples outside RUN and zero-length searches are protocol errors;
  // a start while RUN/DONE is silently ignored.
  assign proto_err_s    = (mse_valid_s & (state_r != MSE_COMP_RUN)) |
                          ((state_r == MSE_COMP_IDLE) & start_s &
                           (library_size_s == {HSP_LIBRARY_WIDTH{1'b0}}));
  // Extremes are emptied by clear and at the beginning of every new search.
  assign ext_clear_s    = clear_s | start_accept_s;
  assign first_sample_s = (count_r == {HSP_LIBRARY_WIDTH{1'b0}});

  // Next-state logic.
  always_comb begin
    state_next = state_r;
    case (state_r)
      MSE_COMP_IDLE: begin
        if (start_accept_s) begin
          state_next = MSE_COMP_RUN;
        end else begin
          state_next = MSE_COMP_IDLE;
        end
      end
      MSE_COMP_RUN: begin
        if (last_valid_s) begin
          state_next = MSE_COMP_DONE;
        end else begin
          state_next = MSE_COMP_RUN;
        end
      end
      MSE_COMP_DONE: begin
        state_next = MSE_COMP_IDLE;
      end
      default: begin
        state_next = MSE_COMP_IDLE;
      end
    endcase
  end

  // State, counters, status outputs and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= MSE_COMP_IDLE;
      count_r   <= {HSP_LIBRARY_WIDTH{1'b0}};
      size_r    <= {HSP_LIBRARY_WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      of_seen_r <= 1'b0;
      error_r   <= 1'b0;
    end else if (clear_s) begin
      state_r   <= MSE_COMP_IDLE;
      count_r   <= {HSP_LIBRARY_WIDTH{1'b0}};
      size_r    <= {HSP_LIBRARY_WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      of_seen_r <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      state_r <= state_next;
      busy_r  <= (state_next == MSE_COMP_RUN);
      done_r  <= (state_next == MSE_COMP_DONE);

      if (start_accept_s) begin
        size_r <= library_size_s;
      end else begin
        size_r <= size_r;
      end

      if (start_accept_s) begin
        count_r <= {HSP_LIBRARY_WIDTH{1'b0}};
      end else if (last_valid_s) begin
        count_r <= {HSP_LIBRARY_WIDTH{1'b0}};
      end else if (run_sample_s) begin
        count_r <= count_r + HSP_LIBRARY_WIDTH'(1);
      end else begin
        count_r <= count_r;
      end

      if (start_accept_s) begin
        of_seen_r <= 1'b0;
      end else if (run_sample_s & ovf_s) begin
        of_seen_r <= 1'b1;
      end else begin
        of_seen_r <= of_seen_r;
      end

      if (proto_err_s) begin
        error_r <= 1'b1;
      end else begin
        error_r <= error_r;
      end
    end
  end

  hsid_mse_extreme #(
    .WORD_WIDTH        (WORD_WIDTH),
    .HSP_LIBRARY_WIDTH (HSP_LIBRARY_WIDTH),
    .IS_MAX            (1'b0)
  ) u_min (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (ext_clear_s),
    .sample_valid (run_sample_s),
    .first_sample (first_sample_s),
    .sample_value (eff_value_s),
    .sample_ref   (bus.mse_ref),
    .ext_value    (min_value_s),
    .ext_ref      (min_ref_s)
  );

  hsid_mse_extreme #(
    .WORD_WIDTH        (WORD_WIDTH),
    .HSP_LIBRARY_WIDTH (HSP_LIBRARY_WIDTH),
    .IS_MAX            (1'b1)
  ) u_max (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (ext_clear_s),
    .sample_valid (run_sample_s),
    .first_sample (first_sample_s),
    .sample_value (eff_value_s),
    .sample_ref   (bus.mse_ref),
    .ext_value    (max_value_s),
    .ext_ref      (max_ref_s)
  );

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.min_value = min_value_s;
  assign bus.min_ref   = min_ref_s;
  assign bus.max_value = max_value_s;
  assign bus.max_ref   = max_ref_s;
  assign bus.of_seen   = of_seen_r;
  assign bus.error     = error_r;

endmodule

// File: tb/tb_hsid_mse_comp.sv
// -----------------------------------------------------------------------------
// tb_hsid_mse_comp
// Directed bench for hsid_mse_comp with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_hsid_mse_comp;
  import hsid_mse_comp_pkg::*;

  localparam int WW = 32;
  localparam int LW = 8;

  logic clk;
  logic rst_n;
  int   assert_cnt;
  int   fail_cnt;

  hsid_mse_comp_if #(.WORD_WIDTH(WW), .HSP_LIBRARY_WIDTH(LW)) bus ();

  hsid_mse_comp #(.WORD_WIDTH(WW), .HSP_LIBRARY_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_search(input logic [LW-1:0] size);
    bus.start        = 1'b1;
    bus.library_size = size;
    tick();
    bus.start        = 1'b0;
  endtask

  task automatic sample(input logic [WW-1:0] v, input logic [LW-1:0] r,
                        input logic mof, input logic aof);
    bus.mse_value = v;
    bus.mse_ref   = r;
    bus.mse_of    = mof;
    bus.acc_of    = aof;
    bus.mse_valid = 1'b1;
    tick();
    bus.mse_valid = 1'b0;
    bus.mse_of    = 1'b0;
    bus.acc_of    = 1'b0;
  endtask

  task automatic check_result(input string tag,
                              input logic [WW-1:0] mnv, input logic [LW-1:0] mnr,
                              input logic [WW-1:0] mxv, input logic [LW-1:0] mxr,
                              input logic ofs);
    check_value({tag, "_min_value"}, 64'(bus.min_value), 64'(mnv));
    check_value({tag, "_min_ref"},   64'(bus.min_ref),   64'(mnr));
    check_value({tag, "_max_value"}, 64'(bus.max_value), 64'(mxv));
    check_value({tag, "_max_ref"},   64'(bus.max_ref),   64'(mxr));
    check_value({tag, "_of_seen"},   64'(bus.of_seen),   64'(ofs));
  endtask

  initial begin
    assert_cnt       = 0;
    fail_cnt         = 0;
    rst_n            = 1'b0;
    bus.clear        = 1'b0;
    bus.start        = 1'b0;
    bus.library_size = 8'd0;
    bus.mse_value    = 32'd0;
    bus.mse_ref      = 8'd0;
    bus.mse_valid    = 1'b0;
    bus.mse_of       = 1'b0;
    bus.acc_of       = 1'b0;

    // Reset state
    repeat (2) tick();
    check_value("rst_busy",  64'(bus.busy),  64'd0);
    check_value("rst_done",  64'(bus.done),  64'd0);
    check_value("rst_error", 64'(bus.error), 64'd0);
    check_result("rst", 32'd0, 8'd0, 32'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Search 1: four samples with a tie on the minimum
    begin_search(8'd4);
    check_value("s1_busy", 64'(bus.busy), 64'd1);
    sample(32'd40, 8'd0, 1'b0, 1'b0);
    sample(32'd12, 8'd1, 1'b0, 1'b0);
    sample(32'd90, 8'd2, 1'b0, 1'b0);
    check_value("s1_no_early_done", 64'(bus.done), 64'd0);
    sample(32'd12, 8'd3, 1'b0, 1'b0);
    check_value("s1_done",      64'(bus.done), 64'd1);
    check_value("s1_busy_done", 64'(bus.busy), 64'd0);
    check_result("s1", 32'd12, 8'd1, 32'd90, 8'd2, 1'b0);
    tick();
    check_value("s1_done_pulse", 64'(bus.done), 64'd0);
    check_result("s1_hold", 32'd12, 8'd1, 32'd90, 8'd2, 1'b0);

    // Search 2: overflowed sample saturates to all-ones
    begin_search(8'd3);
    sample(32'd7, 8'd5, 1'b0, 1'b0);
    sample(32'd7, 8'd6, 1'b1, 1'b0);
    sample(32'd3, 8'd7, 1'b0, 1'b0);
    check_value("s2_done", 64'(bus.done), 64'd1);
    check_result("s2", 32'd3, 8'd7, 32'hFFFF_FFFF, 8'd6, 1'b1);
    tick();

    // Search 3: single all-ones sample loads both extremes
    begin_search(8'd1);
    sample(32'hFFFF_FFFF, 8'd9, 1'b0, 1'b0);
    check_value("s3_done", 64'(bus.done), 64'd1);
    check_result("s3", 32'hFFFF_FFFF, 8'd9, 32'hFFFF_FFFF, 8'd9, 1'b0);
    tick();
    check_value("s3_done_pulse", 64'(bus.done), 64'd0);
    check_value("s3_error",      64'(bus.error), 64'd0);

    // Protocol errors: sample in IDLE, then zero-length start
    sample(32'd5, 8'd2, 1'b0, 1'b1);
    check_value("e_idle_error", 64'(bus.error), 64'd1);
    check_result("e_idle_ignored", 32'hFFFF_FFFF, 8'd9, 32'hFFFF_FFFF, 8'd9, 1'b0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check_value("e_clear_error", 64'(bus.error), 64'd0);
    begin_search(8'd0);
    check_value("e_size0_error", 64'(bus.error), 64'd1);
    check_value("e_size0_busy",  64'(bus.busy),  64'd0);
    tick();
    check_value("e_size0_done",  64'(bus.done),  64'd0);
    check_value("e_size0_busy2", 64'(bus.busy),  64'd0);

    // Clear mid-search, then a fresh search with a start during RUN
    begin_search(8'd5);
    sample(32'd50, 8'd1, 1'b0, 1'b0);
    sample(32'd20, 8'd2, 1'b1, 1'b0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check_value("c_busy",  64'(bus.busy),  64'd0);
    check_value("c_done",  64'(bus.done),  64'd0);
    check_value("c_error", 64'(bus.error), 64'd0);
    check_result("c", 32'd0, 8'd0, 32'd0, 8'd0, 1'b0);
    begin_search(8'd2);
    sample(32'd8, 8'd3, 1'b0, 1'b0);
    bus.start        = 1'b1;
    bus.library_size = 8'd7;
    sample(32'd9, 8'd4, 1'b0, 1'b0);
    bus.start        = 1'b0;
    check_value("c2_done",  64'(bus.done),  64'd1);
    check_value("c2_error", 64'(bus.error), 64'd0);
    check_result("c2", 32'd8, 8'd3, 32'd9, 8'd4, 1'b0);
    tick();
    check_value("c2_done_pulse", 64'(bus.done), 64'd0);
    check_value("c2_busy_after", 64'(bus.busy), 64'd0);

    // Asynchronous reset during RUN
    begin_search(8'd3);
    sample(32'd11, 8'd1, 1'b0, 1'b0);
    check_value("r_busy_run", 64'(bus.busy), 64'd1);
    check_value("r_min_run",  64'(bus.min_value), 64'd11);
    #3;
    rst_n = 1'b0;
    #1;
    check_value("r_busy_async", 64'(bus.busy), 64'd0);
    check_result("r_async", 32'd0, 8'd0, 32'd0, 8'd0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    check_value("r_done_after", 64'(bus.done), 64'd0);
    check_value("r_busy_after", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
